// File: rtl/ram64.sv
// ram64 -- 64 x 16-bit random-access memory for the Hack datapath.
//
// Organised as eight 8-word banks selected by address[5:3]; address[2:0]
// picks the word inside a bank. Writes happen on the rising edge of clk
// when load is high. Reads are purely combinational from the addressed word.
// A synchronous active-low reset clears every word and wins over a write.
//
// Ports:
//   in       [15:0]  write data
//   address  [5:0]   word select for read and write
//   load             write enable, active high
//   clk              rising-edge clock
//   out      [15:0]  contents of mem[address], combinational
//   rst_n            synchronous active-low reset, clears all 64 words

module ram64 (
   input  logic [15:0] in,
   input  logic [5:0]  address,
   input  logic        load,
   input  logic        clk,
   output logic [15:0] out,
   input  logic        rst_n
);

   localparam int NUM_BANKS     = 8;
   localparam int WORDS_PER_BANK = 8;
   localparam int NUM_WORDS     = NUM_BANKS * WORDS_PER_BANK;

   logic [2:0]  bank_sel;
   logic [2:0]  word_sel;
   logic [NUM_BANKS-1:0]  bank_load;
   logic [NUM_WORDS-1:0]  word_load;
   logic [15:0] mem [NUM_WORDS];
   logic [15:0] bank_out [NUM_BANKS];

   assign bank_sel = address[5:3];
   assign word_sel = address[2:0];

   // Two-level decode mirrors the bank structure: a bank is enabled only
   // when it is addressed, and within an enabled bank only one word loads.
   always_comb begin
      bank_load = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_load[b] = load && (bank_sel == 3'(b));
      end
   end

   always_comb begin
      word_load = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         for (int w = 0; w < WORDS_PER_BANK; w++) begin
            word_load[b*WORDS_PER_BANK + w] = bank_load[b] && (word_sel == 3'(w));
         end
      end
   end

   // Storage. Reset is checked first so a write presented in a reset cycle
   // is dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            mem[i] <= 16'h0000;
         end
      end else begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            if (word_load[i]) begin
               mem[i] <= in;
            end
         end
      end
   end

   // Each bank presents its addressed word; the top level then picks the
   // selected bank. Both stages are combinational, so out tracks address
   // without waiting for a clock edge.
   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_out[b] = mem[{3'(b), word_sel}];
      end
   end

   always_comb begin
      out = bank_out[bank_sel];
   end

endmodule

// File: tb/tb_ram64.sv
module tb_ram64;

   logic [15:0] in;
   logic [5:0]  address;
   logic        load;
   logic        clk;
   logic [15:0] out;
   logic        rst_n;

   int n_checks = 0;
   int n_fail   = 0;

   ram64 dut (
      .in      (in),
      .address (address),
      .load    (load),
      .clk     (clk),
      .out     (out),
      .rst_n   (rst_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        load;
      logic [5:0]  addr;
      logic [15:0] din;
      bit          do_clk;
      bit          pre_chk;
      logic [15:0] pre_exp;
      logic [15:0] exp;
      string       name;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: out=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic l, input logic [5:0] a, input logic [15:0] d);
      rst_n   = r;
      load    = l;
      address = a;
      in      = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "timeout");
   end

   initial begin
      //        rst  ld  addr   din       clk  pre  pre_exp   exp
      vecs[0]  = '{1'b0, 1'b1, 6'd5,  16'hFFFF, 1, 0, 16'h0000, 16'h0000, "reset_clear_a5"};
      vecs[1]  = '{1'b1, 1'b0, 6'd0,  16'h0000, 0, 0, 16'h0000, 16'h0000, "reset_clear_a0"};
      vecs[2]  = '{1'b1, 1'b0, 6'd63, 16'h0000, 0, 0, 16'h0000, 16'h0000, "reset_clear_a63"};
      vecs[3]  = '{1'b1, 1'b1, 6'd0,  16'h0000, 1, 0, 16'h0000, 16'h0000, "write_a0_0"};
      vecs[4]  = '{1'b1, 1'b1, 6'd1,  16'h0001, 1, 1, 16'h0000, 16'h0001, "write_a1_1"};
      vecs[5]  = '{1'b1, 1'b0, 6'd1,  16'hBEEF, 1, 0, 16'h0000, 16'h0001, "noload_holds"};
      vecs[6]  = '{1'b1, 1'b1, 6'd1,  16'h0000, 1, 1, 16'h0001, 16'h0000, "rewrite_a1_0"};
      vecs[7]  = '{1'b1, 1'b1, 6'd7,  16'hA5A5, 1, 1, 16'h0000, 16'hA5A5, "write_a7"};
      vecs[8]  = '{1'b1, 1'b1, 6'd8,  16'h5A5A, 1, 1, 16'h0000, 16'h5A5A, "write_a8"};
      vecs[9]  = '{1'b1, 1'b1, 6'd63, 16'h1234, 1, 1, 16'h0000, 16'h1234, "write_a63"};
      vecs[10] = '{1'b1, 1'b0, 6'd7,  16'h0000, 0, 0, 16'h0000, 16'hA5A5, "comb_read_a7"};
      vecs[11] = '{1'b1, 1'b0, 6'd63, 16'h0000, 0, 0, 16'h0000, 16'h1234, "comb_read_a63"};
      vecs[12] = '{1'b1, 1'b0, 6'd8,  16'h0000, 0, 0, 16'h0000, 16'h5A5A, "comb_read_a8"};
      vecs[13] = '{1'b1, 1'b0, 6'd0,  16'h0000, 0, 0, 16'h0000, 16'h0000, "isolation_a0"};
      vecs[14] = '{1'b1, 1'b0, 6'd1,  16'h0000, 0, 0, 16'h0000, 16'h0000, "isolation_a1"};
      vecs[15] = '{1'b1, 1'b0, 6'd9,  16'h0000, 0, 0, 16'h0000, 16'h0000, "isolation_a9"};

      drive(1'b1, 1'b0, 6'd0, 16'h0000);
      repeat (2) @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vecs[i].rst_n, vecs[i].load, vecs[i].addr, vecs[i].din);
         #1;
         if (vecs[i].pre_chk) check({vecs[i].name, "_pre"}, out, vecs[i].pre_exp);
         if (vecs[i].do_clk) begin
            @(posedge clk);
            #1;
         end
         check(vecs[i].name, out, vecs[i].exp);
         load = 1'b0;
      end

      // No write-through: data changes while load=1 stay invisible until the edge.
      @(negedge clk);
      drive(1'b1, 1'b1, 6'd7, 16'h1111);
      #1 check("no_writethrough_a", out, 16'hA5A5);
      in = 16'h2222;
      #1 check("no_writethrough_b", out, 16'hA5A5);
      @(posedge clk);
      #1 check("write_after_edge", out, 16'h2222);
      load = 1'b0;

      // Bank boundaries: every address holds its own index.
      for (int a = 0; a < 64; a++) begin
         @(negedge clk);
         drive(1'b1, 1'b1, 6'(a), 16'(a));
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      load = 1'b0;
      for (int a = 0; a < 64; a++) begin
         address = 6'(a);
         #1 check($sformatf("bank_readback_a%0d", a), out, 16'(a));
      end

      // Reset priority: write attempt during reset is discarded, all data cleared.
      @(negedge clk);
      drive(1'b0, 1'b1, 6'd8, 16'hFFFF);
      #1 check("reset_pre_edge_read", out, 16'h0008);
      @(posedge clk);
      #1 check("reset_priority_a8", out, 16'h0000);
      @(negedge clk);
      drive(1'b1, 1'b0, 6'd0, 16'h0000);
      for (int a = 0; a < 64; a++) begin
         address = 6'(a);
         #1 check($sformatf("reset_cleared_a%0d", a), out, 16'h0000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
